jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//  Drives a bank of WIDTH external JK flip-flops to a requested target state. It is
//  the control end of the JK interface: it emits j/k excitations and reads q back.
//  Accepts a target on a valid/ready handshake and derives j/k from the JK
//  excitation table and the live q feedback. Confirms convergence, then reports
//  done, or err after a timeout.
// PARAMETERS
//  WIDTH       4  number of JK flip-flops driven (j/k/q_fb width)
//  TIMEOUT     4  CHECK cycles allowed for q_fb to match before err (>=1)
//  USE_TOGGLE  0  0: change via set/reset (j=1,k=0 / j=0,k=1); 1: change via j=k=1
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset (0 = in reset)
//  tgt_valid  in   1      target request valid
//  tgt_data   in   WIDTH  requested flip-flop state
//  tgt_ready  out  1      block idle and able to accept a target
//  q_fb       in   WIDTH  q outputs of the driven JK flip-flops
//  j          out  WIDTH  J excitation, registered
//  k          out  WIDTH  K excitation, registered
//  busy       out  1      operation in progress (APPLY or CHECK)
//  done       out  1      one-cycle pulse: q_fb matched target
//  err        out  1      one-cycle pulse: timeout without match
//  err_mask   out  WIDTH  q_fb^target captured at err; held until next accept
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; j,k,err_mask=0; done,err,busy,tgt_ready=0.
//  tgt_ready is registered and rises on the first clk edge after reset releases.
//  FSM IDLE -> APPLY -> CHECK -> IDLE.
//  IDLE: tgt_ready=1. Accept when tgt_valid & tgt_ready at edge E0:
//    tgt_reg<=tgt_data, j/k<=excite(q_fb@E0, tgt_data), tgt_ready<=0, busy<=1,
//    err_mask<=0, state<=APPLY.
//  Excitation, per bit (q->t):
//    q==t: j=0, k=0 (hold).
//    USE_TOGGLE=0: 0->1 gives j=1,k=0; 1->0 gives j=0,k=1.
//    USE_TOGGLE=1: any change gives j=1,k=1.
//  APPLY lasts exactly 1 cycle. External FFs sample j/k at E1.
//    At E1: j,k<=0, cnt<=0, state<=CHECK.
//  CHECK, each edge:
//    q_fb==tgt_reg: done<=1 for 1 cycle, busy<=0, state<=IDLE, tgt_ready<=1.
//    else if cnt==TIMEOUT-1: err<=1 for 1 cycle, err_mask<=q_fb^tgt_reg, state<=IDLE.
//    else: cnt++.
//  Latency: a responsive FF bank gives done high in the cycle after E2 (accept+2).
//  Throughput: at most 1 operation per 3 cycles. tgt_valid held high re-accepts on
//    the edge after done/err.
//  done and err are never high together. j and k are 0 outside APPLY.
//  Target equal to current q: j=k=0 in APPLY; done still at accept+2.
//  q_fb changes in IDLE are ignored. tgt_data is sampled only at accept.
//  cnt width is $clog2(TIMEOUT)+1; cnt does not wrap.
//  Reset mid-operation: j/k drop to 0 immediately; no done/err is emitted.
// STRUCTURE
//  Package jk_pkg: typedef enum logic [1:0] {IDLE, APPLY, CHECK} jk_state_t;
//    function jk_excite(q, t, use_toggle) returns {j, k} per bit.
//  No sub-module. Single always_ff for FSM/regs, always_comb for excitation vector.
// TESTING
//  Bench closes the loop with a behavioural bank of WIDTH JK flip-flops on the same clk.
//  1 reset=0 for 2 cycles -> j=k=0, tgt_ready=0, done=err=0; tgt_ready=1 one edge
//    after release.
//  2 q=0000, tgt 1010 -> APPLY j=1010,k=0000; q=1010; done pulse at accept+2.
//  3 q=1010, tgt 0110: USE_TOGGLE=0 -> j=0100,k=1000; USE_TOGGLE=1 -> j=k=1100;
//    done at accept+2.
//  4 Loop open (q_fb stuck 0000), tgt 1111, TIMEOUT=4 -> err pulse after 4 CHECK
//    edges; err_mask=1111; no done.
//  5 tgt 0110 equal to q -> j=k=0000 throughout; done at accept+2.
//  6 reset=0 during APPLY -> j/k=0 asynchronously; no done/err; next accept works
//    normally.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the JK excitation table used by jk_excitation_driver.
// Kept in a package so the bench and any checkers decode state the same way.
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2
   } jk_state_t;

   // Returns {j, k} that moves one flip-flop from q to t on the next edge.
   function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic use_toggle);
      logic [1:0] jk;
      if (q == t)
         jk = 2'b00;
      else if (use_toggle)
         jk = 2'b11;
      else if (t)
         jk = 2'b10;
      else
         jk = 2'b01;
      return jk;
   endfunction

endpackage

// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flip-flops to a requested state, then watches q_fb
// until it matches (done) or the CHECK window expires (err).
module jk_excitation_driver
   import jk_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int TIMEOUT    = 4,
   parameter bit USE_TOGGLE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_mask,
   output jk_state_t        dbg_state
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   jk_state_t        state, state_nxt;
   logic [WIDTH-1:0] tgt_reg, tgt_nxt;
   logic [WIDTH-1:0] j_nxt, k_nxt, mask_nxt;
   logic [WIDTH-1:0] j_exc, k_exc;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             ready_nxt, busy_nxt, done_nxt, err_nxt;

   assign dbg_state = state;

   // Excitation is derived from the live q_fb at the accepting edge, not from a
   // remembered copy, so the bank may have been disturbed while we were idle.
   always_comb begin
      j_exc = '0;
      k_exc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {j_exc[i], k_exc[i]} = jk_excite(q_fb[i], tgt_data[i], USE_TOGGLE);
      end
   end

   // Handshake: a target transfers on a rising edge where tgt_valid and tgt_ready
   // are both high; tgt_ready is registered and only high while IDLE, and
   // tgt_data is not looked at outside that edge.
   always_comb begin
      state_nxt = state;
      tgt_nxt   = tgt_reg;
      j_nxt     = j;
      k_nxt     = k;
      cnt_nxt   = cnt;
      ready_nxt = tgt_ready;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      mask_nxt  = err_mask;
      case (state)
         IDLE: begin
            if (tgt_valid && tgt_ready) begin
               tgt_nxt   = tgt_data;
               j_nxt     = j_exc;
               k_nxt     = k_exc;
               ready_nxt = 1'b0;
               busy_nxt  = 1'b1;
               mask_nxt  = '0;
               state_nxt = APPLY;
            end else begin
               ready_nxt = 1'b1;
            end
         end
         APPLY: begin
            j_nxt     = '0;
            k_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (q_fb == tgt_reg) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               ready_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               err_nxt   = 1'b1;
               mask_nxt  = q_fb ^ tgt_reg;
               busy_nxt  = 1'b0;
               ready_nxt = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            j_nxt     = '0;
            k_nxt     = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tgt_reg   <= '0;
         j         <= '0;
         k         <= '0;
         cnt       <= '0;
         tgt_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_mask  <= '0;
      end else begin
         state     <= state_nxt;
         tgt_reg   <= tgt_nxt;
         j         <= j_nxt;
         k         <= k_nxt;
         cnt       <= cnt_nxt;
         tgt_ready <= ready_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         err_mask  <= mask_nxt;
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Closed-loop bench: two drivers (set/reset and toggle excitation) each steer their
// own behavioural JK bank; a scoreboard queue per driver checks every done/err.
module tb_jk_excitation_driver;
   import jk_pkg::*;

   localparam int W   = 4;
   localparam int TO  = 4;
   localparam int EW  = 1 + W + 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             bank_rst_n;
   logic             loop_open;
   logic             tgt_valid;
   logic [W-1:0]     tgt_data;

   logic [W-1:0]     j_s [2];
   logic [W-1:0]     k_s [2];
   logic [W-1:0]     qb_s [2];
   logic [W-1:0]     qf_s [2];
   logic [W-1:0]     em_s [2];
   logic             rdy_s [2];
   logic             busy_s [2];
   logic             done_s [2];
   logic             err_s [2];
   jk_state_t        st_s [2];

   logic [EW-1:0]    exp_qa[$];
   logic [EW-1:0]    exp_qb[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs and behavioural JK banks ----------------
   jk_excitation_driver #(.WIDTH(W), .TIMEOUT(TO), .USE_TOGGLE(1'b0)) u_set (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(rdy_s[0]), .q_fb(qf_s[0]), .j(j_s[0]), .k(k_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .err_mask(em_s[0]),
      .dbg_state(st_s[0]));

   jk_excitation_driver #(.WIDTH(W), .TIMEOUT(TO), .USE_TOGGLE(1'b1)) u_tog (
      .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(rdy_s[1]), .q_fb(qf_s[1]), .j(j_s[1]), .k(k_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .err_mask(em_s[1]),
      .dbg_state(st_s[1]));

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!bank_rst_n) qb_s[d] <= '0;
         else             qb_s[d] <= (j_s[d] & ~qb_s[d]) | (~k_s[d] & qb_s[d]);
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) qf_s[d] = loop_open ? '0 : qb_s[d];
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (done_s[d] || err_s[d]) begin
            logic [EW-1:0] e;
            int            qsz;
            qsz = (d == 0) ? exp_qa.size() : exp_qb.size();
            check("done_err_exclusive", d, 64'(done_s[d] & err_s[d]), 64'd0);
            if (qsz == 0) begin
               check("unexpected_completion", d, 64'(qsz), 64'd1);
            end else begin
               e = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
               check("completion_kind_err", d, 64'(err_s[d]), 64'(e[EW-1]));
               check("completion_cycle", d, 64'(cyc), 64'(e[31:0]));
               if (err_s[d]) check("err_mask", d, 64'(em_s[d]), 64'(e[EW-2 -: W]));
               check("jk_idle_zero", d, 64'({j_s[d], k_s[d]}), 64'd0);
               check("busy_clear", d, 64'(busy_s[d]), 64'd0);
               check("ready_back", d, 64'(rdy_s[d]), 64'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Issues one target; checks the APPLY-cycle excitation of both drivers and
   // optionally pushes the expected completion.
   task automatic send(input logic [W-1:0] tgt,
                       input logic [W-1:0] ja, input logic [W-1:0] ka,
                       input logic [W-1:0] jb, input logic [W-1:0] kb,
                       input bit push, input bit is_err, input logic [W-1:0] mask);
      int waited;
      int acc;
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_data  = tgt;
      waited    = 0;
      while (!(rdy_s[0] && rdy_s[1]) && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 40) begin
         check("ready_timeout", 0, 64'(waited), 64'd0);
         tgt_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc       = cyc;
      tgt_valid = 1'b0;
      tgt_data  = ~tgt;
      check("apply_j", 0, 64'(j_s[0]), 64'(ja));
      check("apply_k", 0, 64'(k_s[0]), 64'(ka));
      check("apply_j", 1, 64'(j_s[1]), 64'(jb));
      check("apply_k", 1, 64'(k_s[1]), 64'(kb));
      for (int d = 0; d < 2; d++) begin
         check("apply_busy", d, 64'(busy_s[d]), 64'd1);
         check("apply_mask_cleared", d, 64'(em_s[d]), 64'd0);
      end
      if (push) begin
         logic [EW-1:0] e;
         e = {is_err, mask, 32'(acc + (is_err ? TO + 1 : 2))};
         exp_qa.push_back(e);
         exp_qb.push_back(e);
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while ((exp_qa.size() != 0 || exp_qb.size() != 0) && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("drain_pending", 0, 64'(exp_qa.size() + exp_qb.size()), 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b0;
      bank_rst_n = 1'b0;
      loop_open  = 1'b0;
      tgt_valid  = 1'b0;
      tgt_data   = '0;

      // reset state, then tgt_ready one edge after release
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_jk", d, 64'({j_s[d], k_s[d]}), 64'd0);
         check("rst_ready", d, 64'(rdy_s[d]), 64'd0);
         check("rst_done_err_busy", d, 64'({done_s[d], err_s[d], busy_s[d]}), 64'd0);
      end
      reset      = 1'b1;
      bank_rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) check("ready_before_edge", d, 64'(rdy_s[d]), 64'd0);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) check("ready_after_edge", d, 64'(rdy_s[d]), 64'd1);

      // 0000 -> 1010
      send(4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 1'b1, 1'b0, 4'b0000);
      // 1010 -> 0110
      send(4'b0110, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 1'b1, 1'b0, 4'b0000);
      // target equal to current q
      send(4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000);
      drain();

      // open loop: q_fb stuck at 0000, target 1111 -> err after TIMEOUT checks
      loop_open = 1'b1;
      send(4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1111);
      drain();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) check("err_mask_held", d, 64'(em_s[d]), 64'hf);
      loop_open = 1'b0;
      // banks now: set/reset 1111, toggle 0110^1111 = 1001

      // reset during APPLY (target 0000)
      send(4'b0000, 4'b0000, 4'b1111, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0000);
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("midrst_jk", d, 64'({j_s[d], k_s[d]}), 64'd0);
         check("midrst_busy_ready", d, 64'({busy_s[d], rdy_s[d]}), 64'd0);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);

      // recovery: 1111 -> 0101 (set/reset), 1001 -> 0101 (toggle)
      send(4'b0101, 4'b0000, 4'b1010, 4'b1100, 4'b1100, 1'b1, 1'b0, 4'b0000);
      drain();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
